div4_seq: RTL

DIV4_SEQ -- requirements
Module: div4_seq

---
 rtl/div4_pkg.sv | 17 +
 rtl/div_trial_sub.sv | 15 +
 rtl/div4_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div4_pkg.sv
// Shared constants, state encoding and operand helpers for the 4-bit sequential divider.
package div4_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a 2's-complement operand; -8 maps to 4'b1000, which the unsigned core handles.
    function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step: 5-bit remainder minus 4-bit divisor.
module div_trial_sub
    import div4_pkg::*;
(
    input  logic [DIV_W:0]   rem,
    input  logic [DIV_W-1:0] dvs,
    output logic [DIV_W:0]   diff,
    output logic             borrow
);

    always_comb begin
        {borrow, diff} = {1'b0, rem} - {2'b00, dvs};
    end

endmodule

// File: rtl/div4_seq.sv
// 4-bit restoring divider, one quotient bit per cycle.
// Build option: define DIV4_SEQ_SIGNED_EN for 2's-complement operands (truncating toward zero).
//
// state | meaning
// IDLE  | waiting for start; q/r/div0/oflow hold the last result
// CALC  | four restoring steps, counter 3 down to 0; busy high
// DONE  | one cycle with done high and q/r valid
module div4_seq
    import div4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r,
    output logic             div0,
    output logic             oflow
);

    state_t           state;
    logic [1:0]       cnt;
    logic [DIV_W-1:0] dvd;
    logic [DIV_W-1:0] dvs;
    logic [DIV_W-1:0] rem;

    logic [DIV_W:0]   rem_sh;
    logic [DIV_W:0]   diff;
    logic             borrow;
    logic [DIV_W:0]   rem_nx;
    logic [DIV_W-1:0] dvd_nx;
    logic             unused_rem_msb;

    assign rem_sh = {rem, dvd[DIV_W-1]};

    div_trial_sub u_trial (
        .rem    (rem_sh),
        .dvs    (dvs),
        .diff   (diff),
        .borrow (borrow)
    );

    assign rem_nx = borrow ? rem_sh : diff;
    assign dvd_nx = {dvd[DIV_W-2:0], ~borrow};
    // After a step the remainder is always below the divisor, so bit 4 is always clear.
    assign unused_rem_msb = rem_nx[DIV_W];

`ifdef DIV4_SEQ_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic ovf_pend;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            div0  <= 1'b0;
            oflow <= 1'b0;
`ifdef DIV4_SEQ_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (b == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            q     <= '1;
                            r     <= a;
                            div0  <= 1'b1;
                            oflow <= 1'b0;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            cnt   <= 2'd3;
                            rem   <= '0;
                            div0  <= 1'b0;
                            oflow <= 1'b0;
`ifdef DIV4_SEQ_SIGNED_EN
                            dvd      <= mag(a);
                            dvs      <= mag(b);
                            neg_q    <= a[DIV_W-1] ^ b[DIV_W-1];
                            neg_r    <= a[DIV_W-1];
                            ovf_pend <= (a == 4'h8) && (b == 4'hF);
`else
                            dvd <= a;
                            dvs <= b;
`endif
                        end
                    end
                end
                CALC: begin
                    dvd <= dvd_nx;
                    rem <= rem_nx[DIV_W-1:0];
                    if (cnt == 2'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef DIV4_SEQ_SIGNED_EN
                        q     <= neg_q ? (~dvd_nx + 1'b1) : dvd_nx;
                        r     <= neg_r ? (~rem_nx[DIV_W-1:0] + 1'b1) : rem_nx[DIV_W-1:0];
                        oflow <= ovf_pend;
`else
                        q     <= dvd_nx;
                        r     <= rem_nx[DIV_W-1:0];
`endif
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
